// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_owner_t;

    localparam int BYTE_LANES = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit memory bus and byte/word data accesses.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic                  i_byte,
    input  logic [1:0]            i_lane,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W-1:0]     i_rdata,
    output logic [BYTE_LANES-1:0] o_be,
    output logic [DATA_W-1:0]     o_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] w_rshift;

    always_comb begin
        w_rshift = i_rdata >> {i_lane, 3'b000};
        if (i_byte) begin
            o_be    = BYTE_LANES'(1) << i_lane;
            o_wdata = {BYTE_LANES{i_wdata[7:0]}};
            o_rdata = {{(DATA_W-8){1'b0}}, w_rshift[7:0]};
        end else begin
            o_be    = '1;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
//
// state | meaning
// IDLE  | no transaction; grants are issued combinationally this cycle
// REQ   | mem_req held with a stable payload until mem_gnt
// WAIT  | waiting for mem_rvalid; response registered to the owner
// ERR   | misaligned word access; error response next cycle, memory untouched
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_byte,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [BYTE_LANES-1:0] mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [3:0]        STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    arb_state_t            r_state;
    arb_owner_t            r_owner;
    logic [3:0]            r_streak;
    logic                  r_drop;
    logic                  r_byte;
    logic [1:0]            r_lane;
    logic                  r_if_rvalid;
    logic [DATA_W-1:0]     r_if_rdata;
    logic                  r_d_rvalid;
    logic [DATA_W-1:0]     r_d_rdata;
    logic                  r_d_err;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [BYTE_LANES-1:0] r_mem_be;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;

    logic                  w_idle;
    logic                  w_pick_fetch;
    logic                  w_pick_data;
    logic                  w_misalign;
    logic                  w_al_byte;
    logic [1:0]            w_al_lane;
    logic [BYTE_LANES-1:0] w_be;
    logic [DATA_W-1:0]     w_wdata;
    logic [DATA_W-1:0]     w_rdata;

    // Grants are gated by rst_n so nothing is accepted while reset is asserted.
    assign w_idle       = rst_n && (r_state == IDLE);
    assign w_pick_fetch = w_idle && if_req && !flush && (!d_req || r_streak == STREAK_MAX);
    assign w_pick_data  = w_idle && d_req && !w_pick_fetch;
    assign w_misalign   = !d_byte && (d_addr[1:0] != 2'b00);

    // Lane logic sees the live request in IDLE and the latched access afterwards.
    assign w_al_byte = (r_state == IDLE) ? d_byte      : r_byte;
    assign w_al_lane = (r_state == IDLE) ? d_addr[1:0] : r_lane;

    mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .i_byte  (w_al_byte),
        .i_lane  (w_al_lane),
        .i_wdata (d_wdata),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= FETCH;
            r_streak    <= '0;
            r_drop      <= 1'b0;
            r_byte      <= 1'b0;
            r_lane      <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;

            if (!if_req || w_pick_fetch) begin
                r_streak <= '0;
            end else if (w_pick_data && r_streak != STREAK_MAX) begin
                r_streak <= r_streak + 4'd1;
            end

            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_pick_fetch) begin
                        r_owner     <= FETCH;
                        r_state     <= REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= if_addr & WORD_MASK;
                        r_mem_wdata <= '0;
                    end else if (w_pick_data) begin
                        r_owner <= DATA;
                        r_byte  <= d_byte;
                        r_lane  <= d_addr[1:0];
                        if (w_misalign) begin
                            r_state <= ERR;
                        end else begin
                            r_state     <= REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= d_we;
                            r_mem_be    <= w_be;
                            r_mem_addr  <= d_addr & WORD_MASK;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    if (r_owner == FETCH && flush) r_drop <= 1'b1;
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_owner == FETCH && flush) r_drop <= 1'b1;
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                        if (r_owner == FETCH) begin
                            // A flush landing on the response cycle also kills the fetch.
                            r_if_rvalid <= !(r_drop || flush);
                            r_if_rdata  <= mem_rdata;
                        end else begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_mem_we ? '0 : w_rdata;
                        end
                    end
                end
                ERR: begin
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= 1'b1;
                    r_d_rdata  <= '0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_gnt    = w_pick_fetch;
    assign d_gnt     = w_pick_data;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: data-access vector table plus arbitration, flush and reset sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_byte     (d_byte),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic w_any_out;
    assign w_any_out = |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
                         mem_req, mem_we, mem_be, mem_addr, mem_wdata};

    typedef struct {
        logic        we;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          gwait;
        logic        err;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs[10];
    int          n_chk = 0;
    int          n_err = 0;
    bit          m_resp;
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Memory model: response one cycle after acceptance, accept only when allowed.
    task automatic cyc_start();
        @(negedge clk);
        mem_rvalid = m_resp;
        mem_rdata  = m_rd;
        m_resp     = 1'b0;
        mem_gnt    = 1'b0;
    endtask

    task automatic cyc_end(input bit allow);
        #1;
        if (mem_req && allow) begin
            mem_gnt = 1'b1;
            m_resp  = 1'b1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          t;
        int          cnt;
        int          lat;
        bit          any_req;
        bit          unstable;
        logic [31:0] rd;
        logic        er;
        string       tag;
        tag      = $sformatf("v%0d", idx);
        m_rd     = v.mrd;
        cnt      = 0;
        lat      = -1;
        any_req  = 1'b0;
        unstable = 1'b0;
        rd       = '0;
        er       = 1'b0;
        cyc_start();
        d_req   = 1'b1;
        d_we    = v.we;
        d_byte  = v.byt;
        d_addr  = v.addr;
        d_wdata = v.wdata;
        cyc_end(1'b1);
        t = 0;
        while (!d_gnt && t < 10) begin
            cyc_start();
            cyc_end(1'b1);
            t++;
        end
        chk({tag, "_gnt_delay"}, t, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc_start();
            if (k == 1) d_req = 1'b0;
            cyc_end(cnt >= v.gwait);
            if (mem_req) begin
                any_req = 1'b1;
                if (cnt == 0) begin
                    chk({tag, "_mem_we"},    mem_we,    v.we);
                    chk({tag, "_mem_be"},    mem_be,    v.be);
                    chk({tag, "_mem_addr"},  mem_addr,  v.maddr);
                    chk({tag, "_mem_wdata"}, mem_wdata, v.mwdata);
                end else if (mem_we !== v.we || mem_be !== v.be ||
                             mem_addr !== v.maddr || mem_wdata !== v.mwdata) begin
                    unstable = 1'b1;
                end
                cnt++;
            end
            if (d_rvalid) begin
                lat = k;
                rd  = d_rdata;
                er  = d_err;
                break;
            end
        end
        chk({tag, "_rvalid_lat"}, lat, v.err ? 2 : 3 + v.gwait);
        chk({tag, "_mem_touched"}, any_req, !v.err);
        chk({tag, "_rdata"}, rd, v.rdata);
        chk({tag, "_err"}, er, v.err);
        if (!v.err) begin
            chk({tag, "_req_cycles"}, cnt, v.gwait + 1);
            chk({tag, "_payload_stable"}, unstable, 0);
        end
        cyc_start();
        cyc_end(1'b1);
        chk({tag, "_rvalid_pulse"}, d_rvalid, 0);
    endtask

    logic        got_f[10];
    int          ng;
    int          n_ifrv;
    bit          both;
    bit          ifrv_seen;
    logic [31:0] if_rd;
    logic [31:0] rd_s;
    int          lat_s;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //         we    byt   addr          wdata         mrd           gw err  be     maddr         mwdata        rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'hF, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0203, 32'h0000_005A, 32'hFFFF_FFFF, 0, 1'b0, 4'h8, 32'h0000_0200, 32'h5A5A_5A5A, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0301, 32'h0,        32'h1122_3344, 0, 1'b0, 4'h2, 32'h0000_0300, 32'h0,        32'h0000_0033};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0302, 32'h0,        32'h9999_9999, 0, 1'b1, 4'h0, 32'h0,        32'h0,        32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_040C, 32'hCAFE_F00D, 32'h0,        5, 1'b0, 4'hF, 32'h0000_040C, 32'hCAFE_F00D, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0500, 32'h0,        32'h1122_3344, 0, 1'b0, 4'h1, 32'h0000_0500, 32'h0,        32'h0000_0044};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0503, 32'h0,        32'hA1B2_C3D4, 2, 1'b0, 4'h8, 32'h0000_0500, 32'h0,        32'h0000_00A1};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0601, 32'h1234_5678, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0,        32'h0};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0702, 32'h1234_56C3, 32'h0,        0, 1'b0, 4'h4, 32'h0000_0700, 32'hC3C3_C3C3, 32'h0};
        vecs[9] = '{1'b0, 1'b1, 32'h0000_0702, 32'h0,        32'h00FF_0000, 1, 1'b0, 4'h4, 32'h0000_0700, 32'h0,        32'h0000_00FF};

        m_resp     = 1'b0;
        m_rd       = '0;
        rst_n      = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h0000_1000;
        d_req      = 1'b1;
        d_we       = 1'b0;
        d_byte     = 1'b0;
        d_addr     = 32'h0000_0100;
        d_wdata    = '0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", w_any_out, 0);
        @(negedge clk);
        if_req = 1'b0;
        d_req  = 1'b0;
        rst_n  = 1'b1;
        #1;
        chk("idle_after_reset", {mem_req, d_gnt, if_gnt, d_rvalid}, 0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Both requesters held: four data grants, then the waiting fetch is forced through.
        m_rd   = 32'hA5A5_0001;
        ng     = 0;
        n_ifrv = 0;
        both   = 1'b0;
        if_rd  = '0;
        cyc_start();
        if_req  = 1'b1;
        if_addr = 32'h0000_1000;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_byte  = 1'b0;
        d_addr  = 32'h0000_0800;
        d_wdata = '0;
        cyc_end(1'b1);
        for (int k = 0; k < 60; k++) begin
            if (if_gnt || d_gnt) begin
                if (ng < 10) got_f[ng] = if_gnt;
                ng++;
            end
            if (if_rvalid) begin
                n_ifrv++;
                if_rd = if_rdata;
            end
            if (if_rvalid && d_rvalid) both = 1'b1;
            if (ng >= 10) break;
            cyc_start();
            cyc_end(1'b1);
        end
        cyc_start();
        if_req = 1'b0;
        d_req  = 1'b0;
        cyc_end(1'b1);
        for (int k = 0; k < 6; k++) begin
            if (if_rvalid) begin
                n_ifrv++;
                if_rd = if_rdata;
            end
            if (if_rvalid && d_rvalid) both = 1'b1;
            cyc_start();
            cyc_end(1'b1);
        end
        chk("streak_grant_count", ng, 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("streak_grant%0d_is_fetch", i), got_f[i], (i == 4 || i == 9) ? 1 : 0);
        chk("streak_if_rvalid_count", n_ifrv, 2);
        chk("streak_if_rdata", if_rd, 32'hA5A5_0001);
        chk("streak_rvalid_exclusive", both, 0);

        // Flush: blocks fetch in IDLE, then drops a granted fetch's response.
        m_rd = '0;
        cyc_start();
        if_req  = 1'b1;
        if_addr = 32'h0000_2000;
        flush   = 1'b1;
        cyc_end(1'b0);
        chk("flush_idle_blocks_fetch", if_gnt, 0);
        cyc_start();
        flush = 1'b0;
        cyc_end(1'b0);
        chk("flush_fetch_gnt", if_gnt, 1);
        cyc_start();
        if_req = 1'b0;
        cyc_end(1'b1);
        chk("flush_mem_req", mem_req, 1);
        chk("flush_mem_addr", mem_addr, 32'h0000_2000);
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        m_resp     = 1'b0;
        flush      = 1'b1;
        #1;
        chk("flush_in_wait_no_req", mem_req, 0);
        @(negedge clk);
        flush      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        d_req      = 1'b1;
        d_we       = 1'b0;
        d_byte     = 1'b0;
        d_addr     = 32'h0000_0900;
        #1;
        chk("flush_rsp_cycle_no_gnt", d_gnt, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("flush_if_rvalid_suppressed", if_rvalid, 0);
        chk("flush_next_gnt", d_gnt, 1);
        m_rd      = 32'h2468_0ACE;
        ifrv_seen = 1'b0;
        lat_s     = -1;
        rd_s      = '0;
        for (int k = 1; k <= 10; k++) begin
            cyc_start();
            if (k == 1) d_req = 1'b0;
            cyc_end(1'b1);
            if (if_rvalid) ifrv_seen = 1'b1;
            if (d_rvalid) begin
                lat_s = k;
                rd_s  = d_rdata;
                break;
            end
        end
        chk("flush_followup_lat", lat_s, 3);
        chk("flush_followup_rdata", rd_s, 32'h2468_0ACE);
        chk("flush_no_late_if_rvalid", ifrv_seen, 0);

        // Reset while waiting for the memory response: silent return to IDLE.
        m_rd = 32'h7777_7777;
        cyc_start();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_byte = 1'b0;
        d_addr = 32'h0000_0A00;
        cyc_end(1'b1);
        chk("rst_seq_gnt", d_gnt, 1);
        cyc_start();
        d_req = 1'b0;
        cyc_end(1'b1);
        chk("rst_seq_mem_req", mem_req, 1);
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        m_resp     = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rst_in_wait_outputs", w_any_out, 0);
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        chk("rst_held_outputs", w_any_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("rst_no_response", {if_rvalid, d_rvalid, mem_req}, 0);
        @(negedge clk);
        #1;
        chk("rst_still_quiet", {if_rvalid, d_rvalid, mem_req}, 0);

        run_vec(10, vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
